// File: rtl/multilane_serializer_pkg.sv
// multilane_serializer_pkg: shared constants, types and length/beat/keep helpers.
// SERIALIZER_LSB_FIRST_EN switches keep_mask to LSB-aligned partial beats.
package multilane_serializer_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned LANES_DEF   = 1;
    localparam int unsigned MIN_LEN_DEF = 3;
    localparam int unsigned MAX_LANES   = 8;

    typedef logic [8:0] len_t;
    typedef logic [8:0] beat_cnt_t;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic len_t calc_len(input int unsigned mod, input int unsigned width);
        return (mod == 0) ? len_t'(width) : len_t'(mod);
    endfunction

    function automatic beat_cnt_t calc_beats(input len_t len, input int unsigned lanes);
        return beat_cnt_t'((32'(len) + lanes - 1) / lanes);
    endfunction

    function automatic logic [MAX_LANES-1:0] keep_mask(input len_t remaining, input int unsigned lanes);
        int unsigned r;
        r = (32'(remaining) >= lanes) ? lanes : 32'(remaining);
`ifdef SERIALIZER_LSB_FIRST_EN
        return MAX_LANES'((1 << r) - 1);
`else
        return MAX_LANES'(((1 << r) - 1) << (lanes - r));
`endif
    endfunction

endpackage

// File: rtl/multilane_serializer_if.sv
// multilane_serializer_if: parallel-word input handshake and lane-beat output stream.
interface multilane_serializer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 1
);
    logic [WIDTH-1:0]         data_i;
    logic [$clog2(WIDTH)-1:0] data_mod_i;
    logic                     data_val_i;
    logic                     data_rdy_o;
    logic [LANES-1:0]         ser_data_o;
    logic                     ser_data_val_o;
    logic                     ser_data_last_o;
    logic [LANES-1:0]         ser_data_keep_o;

    modport master (
        output data_i, data_mod_i, data_val_i,
        input  data_rdy_o, ser_data_o, ser_data_val_o, ser_data_last_o, ser_data_keep_o
    );

    modport slave (
        input  data_i, data_mod_i, data_val_i,
        output data_rdy_o, ser_data_o, ser_data_val_o, ser_data_last_o, ser_data_keep_o
    );
endinterface

// File: rtl/multilane_serializer_ser_shift_stage.sv
// ser_shift_stage: shift register, beat counter and last/keep generation.
// SERIALIZER_LSB_FIRST_EN takes beats from the low end and shifts right.
module ser_shift_stage
    import multilane_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  len_t             len_i,
    output logic [LANES-1:0] ser_data_o,
    output logic             ser_data_val_o,
    output logic             ser_data_last_o,
    output logic [LANES-1:0] ser_data_keep_o,
    output logic             active_o,
    output logic             done_o
);

    state_t                 state_q;
    logic [WIDTH-1:0]       sr_q, sr_d, src_w;
    beat_cnt_t              cnt_q, cnt_d, src_cnt;
    len_t                   tail_q, src_tail;
    logic [MAX_LANES-1:0]   tail_mask;
    logic [LANES-1:0]       data_d, keep_d;
    logic                   last_d;

    // A load replaces whatever the shifter would have emitted next.
    always_comb begin
        src_w     = load_i ? data_i : sr_q;
        src_cnt   = load_i ? calc_beats(len_i, LANES) : cnt_q;
        src_tail  = load_i ? len_t'((32'(len_i) - 1) % LANES + 1) : tail_q;
        tail_mask = keep_mask(src_tail, LANES);
        last_d    = src_cnt == beat_cnt_t'(1);
        keep_d    = last_d ? tail_mask[LANES-1:0] : '1;
`ifdef SERIALIZER_LSB_FIRST_EN
        data_d    = src_w[LANES-1:0] & keep_d;
        sr_d      = src_w >> LANES;
`else
        data_d    = src_w[WIDTH-1 -: LANES] & keep_d;
        sr_d      = src_w << LANES;
`endif
        cnt_d     = src_cnt - beat_cnt_t'(1);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q         <= IDLE;
            ser_data_o      <= '0;
            ser_data_val_o  <= 1'b0;
            ser_data_last_o <= 1'b0;
            ser_data_keep_o <= '0;
        end else if (load_i || (state_q == SHIFT && !ser_data_last_o)) begin
            state_q         <= SHIFT;
            ser_data_o      <= data_d;
            ser_data_val_o  <= 1'b1;
            ser_data_last_o <= last_d;
            ser_data_keep_o <= keep_d;
            sr_q            <= sr_d;
            cnt_q           <= cnt_d;
            tail_q          <= src_tail;
        end else begin
            state_q         <= IDLE;
            ser_data_o      <= '0;
            ser_data_val_o  <= 1'b0;
            ser_data_last_o <= 1'b0;
            ser_data_keep_o <= '0;
        end
    end

    assign active_o = state_q == SHIFT;
    assign done_o   = state_q == SHIFT && ser_data_last_o;

endmodule

// File: rtl/multilane_serializer.sv
// multilane_serializer: parallel word to LANES-bit beats with a one-word pending register.
// Define SERIALIZER_LSB_FIRST_EN for LSB-first order with LSB-aligned partial beats.
module multilane_serializer
    import multilane_serializer_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned LANES   = LANES_DEF,
    parameter int unsigned MIN_LEN = MIN_LEN_DEF
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    multilane_serializer_if.slave bus,
    output logic                  busy_o
);

    logic [WIDTH-1:0] pend_data_q, load_data;
    len_t             pend_len_q, len, load_len;
    logic             pend_val_q, pend_val_d, pend_load;
    logic             accept, legal, to_shift, load, active, done;

    assign len       = calc_len(32'(bus.data_mod_i), WIDTH);
    assign accept    = bus.data_val_i && !pend_val_q;
    assign legal     = len >= len_t'(MIN_LEN);
    // Accepting implies pending is empty, so a retiring shifter can take the word directly.
    assign to_shift  = accept && legal && (!active || done);
    assign pend_load = accept && legal && !to_shift;
    assign load      = to_shift || (done && pend_val_q);
    assign load_data = pend_val_q ? pend_data_q : bus.data_i;
    assign load_len  = pend_val_q ? pend_len_q : len;
    assign pend_val_d = (done && pend_val_q) ? 1'b0 : pend_load ? 1'b1 : pend_val_q;

    always_ff @(posedge clk_i) begin
        pend_val_q <= srst_i ? 1'b0 : pend_val_d;
        if (pend_load) begin
            pend_data_q <= bus.data_i;
            pend_len_q  <= len;
        end
    end

    ser_shift_stage #(
        .WIDTH(WIDTH),
        .LANES(LANES)
    ) u_shift (
        .clk_i           (clk_i),
        .srst_i          (srst_i),
        .load_i          (load),
        .data_i          (load_data),
        .len_i           (load_len),
        .ser_data_o      (bus.ser_data_o),
        .ser_data_val_o  (bus.ser_data_val_o),
        .ser_data_last_o (bus.ser_data_last_o),
        .ser_data_keep_o (bus.ser_data_keep_o),
        .active_o        (active),
        .done_o          (done)
    );

    assign bus.data_rdy_o = !pend_val_q;
    assign busy_o         = active || pend_val_q;

endmodule

// File: tb/tb_multilane_serializer.sv
// tb_multilane_serializer: scoreboard bench for 4-lane and 1-lane serializer instances.
module tb_multilane_serializer;

    typedef struct packed {
        logic [3:0] d;
        logic       l;
        logic [3:0] k;
    } beat_t;

    logic clk_i = 1'b0;
    logic srst_i;
    logic busy4, busy1;
    logic mon_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   beats4 = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    beat_t q4[$];
    beat_t q1[$];
    beat_t act4, act1;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    multilane_serializer_if #(.WIDTH(16), .LANES(4)) bus4 ();
    multilane_serializer_if #(.WIDTH(16), .LANES(1)) bus1 ();

    multilane_serializer #(.WIDTH(16), .LANES(4), .MIN_LEN(3)) u_dut4 (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .bus    (bus4.slave),
        .busy_o (busy4)
    );

    multilane_serializer #(.WIDTH(16), .LANES(1), .MIN_LEN(3)) u_dut1 (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .bus    (bus1.slave),
        .busy_o (busy1)
    );

    assign act4 = {bus4.ser_data_o, bus4.ser_data_last_o, bus4.ser_data_keep_o};
    assign act1 = {3'b0, bus1.ser_data_o, bus1.ser_data_last_o, 3'b0, bus1.ser_data_keep_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [3:0] d, input logic l, input logic [3:0] k);
        return {d, l, k};
    endfunction

    // Monitor: every valid beat must match the head of the scoreboard; idle outputs must be 0.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (bus4.ser_data_val_o === 1'b1) begin
                if (q4.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat4 got=%h expected=none", act4);
                end else begin
                    chk("beat4", 32'(act4), 32'(q4.pop_front()));
                end
                beats4++;
                if (beats4 == 1) first_cyc = cyc;
                last_cyc = cyc;
            end else begin
                chk("idle4", 32'(act4), 32'd0);
            end
            if (bus1.ser_data_val_o === 1'b1) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat1 got=%h expected=none", act1);
                end else begin
                    chk("beat1", 32'(act1), 32'(q1.pop_front()));
                end
            end else begin
                chk("idle1", 32'(act1), 32'd0);
            end
        end
    end

    task automatic drive4(input logic [15:0] d, input logic [3:0] m);
        bus4.data_i     = d;
        bus4.data_mod_i = m;
        bus4.data_val_i = 1'b1;
        for (int i = 0; i < 100 && bus4.data_rdy_o !== 1'b1; i++) @(negedge clk_i);
        if (bus4.data_rdy_o !== 1'b1) chk("rdy_timeout4", 32'(bus4.data_rdy_o), 32'd1);
        @(negedge clk_i);
    endtask

    task automatic drive1(input logic [15:0] d, input logic [3:0] m);
        bus1.data_i     = d;
        bus1.data_mod_i = m;
        bus1.data_val_i = 1'b1;
        for (int i = 0; i < 100 && bus1.data_rdy_o !== 1'b1; i++) @(negedge clk_i);
        if (bus1.data_rdy_o !== 1'b1) chk("rdy_timeout1", 32'(bus1.data_rdy_o), 32'd1);
        @(negedge clk_i);
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 400 && (busy4 !== 1'b0 || busy1 !== 1'b0); n++) @(negedge clk_i);
        repeat (2) @(negedge clk_i);
        chk(name, 32'({busy4, busy1}), 32'd0);
        chk({name, "_drain4"}, 32'(q4.size()), 32'd0);
        chk({name, "_drain1"}, 32'(q1.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] c, d;
        srst_i          = 1'b1;
        bus4.data_i     = '0;
        bus4.data_mod_i = '0;
        bus4.data_val_i = 1'b0;
        bus1.data_i     = '0;
        bus1.data_mod_i = '0;
        bus1.data_val_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_rdy4", 32'(bus4.data_rdy_o), 32'd1);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_out4", 32'({bus4.ser_data_val_o, act4}), 32'd0);
        chk("rst_rdy1", 32'(bus1.data_rdy_o), 32'd1);
        srst_i = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_i);

        // Full word, MSB-first nibbles
        q4.push_back(mk(4'hA, 1'b0, 4'hF));
        q4.push_back(mk(4'h5, 1'b0, 4'hF));
        q4.push_back(mk(4'hC, 1'b0, 4'hF));
        q4.push_back(mk(4'h3, 1'b1, 4'hF));
        drive4(16'hA5C3, 4'd0);
        bus4.data_val_i = 1'b0;
        chk("latency", 32'(bus4.ser_data_val_o), 32'd1);
        chk("busy_on", 32'(busy4), 32'd1);
        wait_idle("full");

        // Partial last beat: 101101 -> 1011, 01xx
        q4.push_back(mk(4'hB, 1'b0, 4'hF));
        q4.push_back(mk(4'h4, 1'b1, 4'hC));
        drive4(16'hB4FF, 4'd6);
        bus4.data_val_i = 1'b0;
        wait_idle("partial");

        // Rejected short word, then a legal 8-bit word
        drive4(16'hFFFF, 4'd2);
        bus4.data_val_i = 1'b0;
        chk("rej_rdy", 32'(bus4.data_rdy_o), 32'd1);
        chk("rej_busy", 32'(busy4), 32'd0);
        chk("rej_val", 32'(bus4.ser_data_val_o), 32'd0);
        @(negedge clk_i);
        chk("rej_busy2", 32'(busy4), 32'd0);
        q4.push_back(mk(4'h5, 1'b0, 4'hF));
        q4.push_back(mk(4'hA, 1'b1, 4'hF));
        drive4(16'h5A00, 4'd8);
        bus4.data_val_i = 1'b0;
        wait_idle("after_rej");

        // Back-to-back: three full words, val held
        for (int i = 1; i <= 12; i++) q4.push_back(mk(4'(i), (i % 4) == 0, 4'hF));
        beats4 = 0;
        drive4(16'h1234, 4'd0);
        drive4(16'h5678, 4'd0);
        chk("rdy_drop", 32'(bus4.data_rdy_o), 32'd0);
        drive4(16'h9ABC, 4'd0);
        bus4.data_val_i = 1'b0;
        wait_idle("b2b");
        chk("b2b_beats", 32'(beats4), 32'd12);
        chk("b2b_span", 32'(last_cyc - first_cyc), 32'd11);

        // Reset on the second beat with pending full
        q4.push_back(mk(4'hD, 1'b0, 4'hF));
        q4.push_back(mk(4'hE, 1'b0, 4'hF));
        drive4(16'hDEAD, 4'd0);
        drive4(16'hBEEF, 4'd0);
        bus4.data_val_i = 1'b0;
        chk("pend_full", 32'(bus4.data_rdy_o), 32'd0);
        srst_i = 1'b1;
        @(negedge clk_i);
        srst_i = 1'b0;
        chk("mid_rst_out", 32'({bus4.ser_data_val_o, act4}), 32'd0);
        chk("mid_rst_rdy", 32'(bus4.data_rdy_o), 32'd1);
        chk("mid_rst_busy", 32'(busy4), 32'd0);
        repeat (8) @(negedge clk_i);
        wait_idle("mid_rst");

        // Single-lane regression, lengths 3..15, bit-reversed counter data
        for (int l = 3; l <= 15; l++) begin
            c = 16'(l * 16'h1357 + 16'h00A1);
            d = {<<{c}};
            for (int k = 0; k < l; k++) q1.push_back(mk(4'(d[15-k]), k == l - 1, 4'h1));
            drive1(d, 4'(l));
        end
        bus1.data_val_i = 1'b0;
        wait_idle("lanes1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multilane_serializer.md
# multilane_serializer

Parametrised successor to the single-bit serializer. It converts a parallel word of programmable length into a stream of LANES-bit beats, and marks the last beat and the valid lanes within it. A one-word pending register lets the next word be accepted while the current one is shifting, so consecutive words go out with no idle cycle. It sits between packet-formatting logic and narrow serial PHY or line-coding blocks.

## Interface
- WIDTH, 16: parallel word width; must be a multiple of LANES.
- LANES, 1: bits emitted per output beat; legal values are 1, 2, 4, 8.
- MIN_LEN, 3: shortest legal word length in bits; 1 ≤ MIN_LEN ≤ WIDTH.

Ports (reset is synchronous and active-high):
- clk_i  input  1  single clock.
- srst_i  input  1  synchronous active-high reset.
- data_i  input  WIDTH  parallel word.
- data_mod_i  input  $clog2(WIDTH)  word length in bits; 0 means WIDTH.
- data_val_i  input  1  input word valid.
- data_rdy_o  output  1  input can accept a word; equals !pending_valid.
- ser_data_o  output  LANES  output beat; 0 when not valid.
- ser_data_val_o  output  1  output beat valid.
- ser_data_last_o  output  1  last beat of the word.
- ser_data_keep_o  output  LANES  valid lanes in the beat; all ones except on a partial last beat; 0 when not valid.
- busy_o  output  1  shifter active or pending word held.

## Operation
- Handshake: a word transfers when data_val_i && data_rdy_o. Inputs are ignored at all other times.
- Length: len = (data_mod_i == 0) ? WIDTH : data_mod_i. Beats = ceil(len / LANES).
- Rejected length: if 1 ≤ len < MIN_LEN, the handshake completes but the word is discarded. It produces no output and does not change busy_o.
- Bit selection, default mode:
  - Bits come from data_i[WIDTH-1 -: len] and are sent MSB-first.
  - Within a beat, ser_data_o[LANES-1] carries the earliest bit.
  - In a partial last beat, the unused low lanes are 0 and the keep bits are MSB-aligned.
- Two storage stages: the shifter (active word plus beat counter) and the pending register (one word plus its length).
- Routing of an accepted legal word:
  - It loads the shifter if the shifter is idle, or if the shifter is emitting its last beat this cycle while pending is empty.
  - Otherwise it loads the pending register.
- Pending transfer: when the shifter retires its last beat and pending is valid, pending moves into the shifter the same cycle and pending clears.
- States (shifter): IDLE and SHIFT.
  - IDLE → SHIFT on a load.
  - SHIFT → SHIFT on a last beat followed by a reload.
  - SHIFT → IDLE on a last beat with nothing to reload.
- busy_o = shifter_active || pending_valid.
- Reset values: ser_data_o, ser_data_val_o, ser_data_last_o, ser_data_keep_o and busy_o are 0; data_rdy_o is 1.
- Reset mid-word: the shifter and pending word are discarded, and outputs return to reset values on the next cycle.
- Reset while data_val_i is high: reset wins and the word is not accepted.

## Timing
- Latency: a word accepted on edge N drives its first beat during cycle N+1. All outputs are registered.
- A word of b beats occupies the output for exactly b consecutive cycles.
- Back-to-back: with pending valid, or with a new word accepted during the last beat, the next word's first beat immediately follows the previous last beat. There are zero gap cycles.
- data_rdy_o deasserts on the cycle after pending fills. It reasserts on the cycle after pending transfers into the shifter.
- Sustained throughput is one word per ceil(len/LANES) cycles.

## Configuration
- Macro: SERIALIZER_LSB_FIRST_EN.
- When defined:
  - Bits come from data_i[len-1:0] and are sent LSB-first.
  - ser_data_o[0] carries the earliest bit.
  - A partial last beat is LSB-aligned, with zeros in the upper lanes and the keep bits LSB-aligned.
- When undefined: MSB-first behaviour as described in Operation.

## Structure
- serializer_pkg: WIDTH/LANES/MIN_LEN default constants; len_t and beat_cnt_t typedefs; function calc_len(mod) (0 → WIDTH); function calc_beats(len, LANES); function keep_mask(remaining_bits).
- One sub-module, ser_shift_stage: the shift register, beat counter, and last/keep generation. It has a load port and a done strobe.
- The top level contains the pending register, handshake, length check and busy logic.

## Test plan
Unless noted, the bench uses WIDTH=16, LANES=4, MIN_LEN=3.
- Full word: data_i=16'hA5C3, mod=0 → 4 beats A,5,C,3 with keep F on each; last on beat 4; first beat on cycle N+1.
- Partial: data_i=16'hB400 (top 6 bits = 101101), mod=6 → beats 4'b1011 keep F, then 4'b0100 keep 4'b1100 with last.
- Rejected: mod=2 with val → data_rdy_o stays 1, no ser_data_val_o, busy_o stays 0. A following word with mod=8 serialises normally.
- Back-to-back: three words with mod=0, val held high → data_rdy_o drops after the second is accepted. 12 contiguous valid beats with no gaps, last on beats 4, 8 and 12.
- Reset mid-word: srst_i high on the second beat with pending full → next cycle all outputs 0, data_rdy_o=1, busy_o=0; no stale beats afterwards.
- LANES=1 regression: all words for len 3..15 with bit-reversed counter data → bitwise MSB-first match, keep=1, last on bit len.
